instr_fetch_unit: RTL and testbench

//  Single-cycle-CPU front end. Holds the fetch PC and runs a req/ack handshake to

---
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the fetch PC, runs a single-outstanding req/ack to
// instruction memory and queues returned words with their PCs for decode.
//
// state   | meaning
// IDLE    | no request; waiting for queue room
// FETCH   | request for fetch_pc outstanding; acked data is queued
// DISCARD | request for a stale address outstanding; acked data is dropped
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [15:0] imm16_o
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e            state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       target_pc_q;
    logic [31:0]       q_pc_q    [QUEUE_DEPTH];
    logic [31:0]       q_instr_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       redir_pc;
    logic              push;
    logic              pop;

    assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;

    // A redirect kills both the incoming word and any pop in the same cycle.
    assign push = (state_q == S_FETCH) && imem_ack_i && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            target_pc_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= '0;
            end
        end else begin
            if (push) begin
                q_pc_q[wr_ptr_q]    <= fetch_pc_q;
                q_instr_q[wr_ptr_q] <= imem_data_i;
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            if (redirect_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (redirect_i) begin
                        fetch_pc_q <= redir_pc;
                        state_q    <= S_FETCH;
                    end else if (count_q != DEPTH_C) begin
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (redirect_i) begin
                        if (imem_ack_i) begin
                            fetch_pc_q <= redir_pc;
                        end else begin
                            // Address must stay stable until the stale ack lands.
                            target_pc_q <= redir_pc;
                            state_q     <= S_DISCARD;
                        end
                    end else if (imem_ack_i) begin
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                        if (count_d == DEPTH_C) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DISCARD: begin
                    if (imem_ack_i) begin
                        fetch_pc_q <= redirect_i ? redir_pc : target_pc_q;
                        state_q    <= S_FETCH;
                    end else if (redirect_i) begin
                        target_pc_q <= redir_pc;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_req_o    = (state_q == S_FETCH) || (state_q == S_DISCARD);
    assign imem_addr_o   = fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = q_instr_q[rd_ptr_q];
    assign pc_o          = q_pc_q[rd_ptr_q];
    assign pc_plus4_o    = pc_o + 32'd4;
    assign imm16_o       = instr_o[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder pushes expected
// {pc, instr} pairs; a monitor pops and compares on every decode handshake.
module tb_instr_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic [15:0] imm16_o;

    instr_fetch_unit #(
        .RESET_PC    (RST_PC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .imm16_o       (imm16_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    int          n_drops  = 0;
    bit          mon_en   = 1'b0;
    bit          outstanding = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] exp_addr = RST_PC;
    int          epoch     = 0;
    int          redir_cnt = 0;
    int          wait_cnt  = 0;
    int          ack_delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Head of queue is compared just before each rising edge.
    always @(negedge clk_i) begin
        #4;
        if (mon_en) begin
            chk("valid", 32'(instr_valid_o), 32'(sb.size() != 0));
            chk("depth", 32'(sb.size() <= DEPTH), 32'd1);
            if (sb.size() != 0) begin
                chk("head_instr", instr_o, sb[0].instr);
                chk("head_pc", pc_o, sb[0].pc);
                chk("head_pc4", pc_plus4_o, sb[0].pc + 32'd4);
                chk("head_imm16", 32'(imm16_o), 32'(sb[0].instr[15:0]));
                if (instr_ready_i && !redirect_i) begin
                    void'(sb.pop_front());
                    n_pops++;
                end
            end
        end
    end

    task automatic reset_checks();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, RST_PC);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc4", pc_plus4_o, 32'd4);
        chk("rst_imm16", 32'(imm16_o), 32'd0);
    endtask

    task automatic clear_model();
        sb.delete();
        outstanding = 1'b0;
        exp_addr    = RST_PC;
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_model();
        reset_checks();
        @(negedge clk_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;
    endtask

    // One cycle: memory responds to the visible request, decode/redirect inputs
    // are applied, and the reference queue is updated after the edge.
    task automatic step(input logic redir, input logic [31:0] tgt, input logic rdy);
        logic        ack;
        logic [31:0] data;
        entry_t      e;
        @(negedge clk_i);
        ack  = 1'b0;
        data = $urandom;
        if (outstanding) begin
            chk("req_held", 32'(imem_req_o), 32'd1);
            chk("addr_held", imem_addr_o, req_addr);
        end else if (imem_req_o) begin
            outstanding = 1'b1;
            req_addr    = imem_addr_o;
            epoch       = redir_cnt;
            wait_cnt    = 0;
            chk("req_addr", imem_addr_o, exp_addr);
            chk("req_room", 32'(sb.size() < DEPTH), 32'd1);
        end
        if (outstanding) begin
            if (ack_delay < 0) ack = ($urandom_range(0, 2) == 0);
            else               ack = (wait_cnt >= ack_delay);
            wait_cnt++;
        end
        imem_ack_i    = ack;
        imem_data_i   = ack ? data : 32'hDEAD_BEEF;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        instr_ready_i = rdy;
        @(posedge clk_i);
        #1;
        if (ack) begin
            if (redir || epoch != redir_cnt) begin
                n_drops++;
            end else begin
                e.pc    = req_addr;
                e.instr = data;
                sb.push_back(e);
                exp_addr = req_addr + 32'd4;
            end
            outstanding = 1'b0;
        end
        if (redir) begin
            sb.delete();
            redir_cnt++;
            exp_addr = tgt & 32'hFFFF_FFFC;
        end
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    initial begin
        int          p0;
        int          d0;
        logic        r;
        logic [31:0] tgt;

        // Streaming with immediate acks
        do_reset();
        ack_delay = 0;
        p0 = n_pops;
        repeat (12) step(1'b0, 32'd0, 1'b1);
        chk("t1_throughput", 32'(n_pops - p0 >= 8), 32'd1);

        // Decode stalled: queue fills, request drops, then drains in order
        do_reset();
        repeat (6) step(1'b0, 32'd0, 1'b0);
        chk("t2_req_idle", 32'(imem_req_o), 32'd0);
        chk("t2_valid", 32'(instr_valid_o), 32'd1);
        chk("t2_queued", 32'(sb.size()), 32'd2);
        repeat (8) step(1'b0, 32'd0, 1'b1);

        // Redirect with a full queue
        do_reset();
        repeat (6) step(1'b0, 32'd0, 1'b0);
        step(1'b1, 32'h0000_0103, 1'b0);
        chk("t3_valid", 32'(instr_valid_o), 32'd0);
        chk("t3_addr", imem_addr_o, 32'h0000_0100);
        chk("t3_req", 32'(imem_req_o), 32'd1);
        repeat (4) step(1'b0, 32'd0, 1'b1);

        // Redirect while a slow request is pending
        do_reset();
        ack_delay = 3;
        d0 = n_drops;
        p0 = n_pops;
        for (int i = 0; i < 10; i++) begin
            if (outstanding && wait_cnt == 1) begin
                step(1'b1, 32'h0000_0200, 1'b1);
                break;
            end
            step(1'b0, 32'd0, 1'b1);
        end
        repeat (14) step(1'b0, 32'd0, 1'b1);
        chk("t4_dropped", 32'(n_drops - d0), 32'd1);
        chk("t4_progress", 32'(n_pops - p0 >= 1), 32'd1);

        // Redirect coincident with ack and pop
        do_reset();
        ack_delay = 0;
        repeat (5) step(1'b0, 32'd0, 1'b1);
        chk("t5_pre_valid", 32'(instr_valid_o), 32'd1);
        d0 = n_drops;
        step(1'b1, 32'h0000_0400, 1'b1);
        chk("t5_dropped", 32'(n_drops - d0), 32'd1);
        chk("t5_valid", 32'(instr_valid_o), 32'd0);
        chk("t5_addr", imem_addr_o, 32'h0000_0400);
        repeat (6) step(1'b0, 32'd0, 1'b1);

        // Address wrap, then asynchronous reset between edges
        do_reset();
        repeat (3) step(1'b0, 32'd0, 1'b1);
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        chk("t6_pc", pc_o, 32'hFFFF_FFFC);
        chk("t6_pc4", pc_plus4_o, 32'h0000_0000);
        chk("t6_next_addr", imem_addr_o, 32'h0000_0000);
        step(1'b0, 32'd0, 1'b1);
        mon_en = 1'b0;
        #1 rst_i = 1'b0;
        #1 reset_checks();
        clear_model();
        @(negedge clk_i);
        rst_i  = 1'b1;
        mon_en = 1'b1;

        // Randomised traffic
        do_reset();
        ack_delay = -1;
        p0 = n_pops;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 11) == 0);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step(r, tgt, ($urandom_range(0, 3) != 0));
        end
        chk("rand_progress", 32'(n_pops - p0 >= 20), 32'd1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
